// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter for a bank of four ls_reg
// registers sharing one write port.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_clr      synchronous active-high reset (also clears the whole bank)
//   i_req      per-requester write request, held until granted
//   i_addr     per-requester target register, requester i uses [2i+1:2i]
//   i_data     per-requester write data, requester i uses [N*i +: N]
//   i_clr_all  bank-wide clear command
//   o_gnt      one-hot grant pulse to the winning requester
//   o_ld       one-hot load enable, bit j drives c of register j
//   o_rclr_n   active-low clear, bit j drives clr of register j
//   o_wdata    shared write bus to all registers
module wb_arbiter #(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_clr,
  input  logic [3:0]     i_req,
  input  logic [7:0]     i_addr,
  input  logic [4*N-1:0] i_data,
  input  logic           i_clr_all,
  output logic [3:0]     o_gnt,
  output logic [3:0]     o_ld,
  output logic [3:0]     o_rclr_n,
  output logic [N-1:0]   o_wdata
);

  logic [1:0]   r_ptr;
  logic [3:0]   r_gnt;
  logic [3:0]   r_ld;
  logic [3:0]   r_rclr_n;
  logic [N-1:0] r_wdata;

  logic [3:0]   w_elig;
  logic         w_found;
  logic [1:0]   w_win;
  logic [1:0]   w_idx;
  logic [1:0]   w_waddr;
  logic [N-1:0] w_wdat;

  // Last cycle's grantee is masked so it cannot be granted again while
  // it is still dropping its request.
  always_comb begin
    w_elig  = i_req & ~r_gnt;
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_waddr = 2'd0;
    w_wdat  = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_win == 2'(k)) begin
        w_waddr = i_addr[2*k +: 2];
        w_wdat  = i_data[N*k +: N];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_gnt    <= 4'b0000;
      r_ld     <= 4'b0000;
      r_wdata  <= '0;
      r_ptr    <= 2'd0;
      r_rclr_n <= 4'b0000;
    end else if (i_clr_all) begin
      // Pointer and bus hold; pending requests arbitrate once the command drops.
      r_gnt    <= 4'b0000;
      r_ld     <= 4'b0000;
      r_rclr_n <= 4'b0000;
    end else begin
      r_rclr_n <= 4'b1111;
      if (w_found) begin
        r_gnt   <= 4'b0001 << w_win;
        r_ld    <= 4'b0001 << w_waddr;
        r_wdata <= w_wdat;
        r_ptr   <= w_win + 2'd1;
      end else begin
        r_gnt <= 4'b0000;
        r_ld  <= 4'b0000;
      end
    end
  end

  assign o_gnt    = r_gnt;
  assign o_ld     = r_ld;
  assign o_rclr_n = r_rclr_n;
  assign o_wdata  = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic           clr_all = 1'b0;
  logic [3:0]     req = 4'b0000;
  logic [1:0]     ra [4];
  logic [N-1:0]   rd [4];
  logic [7:0]     addr;
  logic [4*N-1:0] data;
  logic [3:0]     o_gnt, o_ld, o_rclr_n;
  logic [N-1:0]   o_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr = '0;
    data = '0;
    for (int k = 0; k < 4; k++) begin
      addr[2*k +: 2] = ra[k];
      data[N*k +: N] = rd[k];
    end
  end

  wb_arbiter #(.N(N)) dut (
    .i_clk(clk), .i_clr(clr), .i_req(req), .i_addr(addr), .i_data(data),
    .i_clr_all(clr_all), .o_gnt(o_gnt), .o_ld(o_ld), .o_rclr_n(o_rclr_n),
    .o_wdata(o_wdata)
  );

  // Register bank driven by the DUT (the environment, not a reference).
  logic [N-1:0] bank [4];
  always @(posedge clk)
    for (int j = 0; j < 4; j++)
      if (!o_rclr_n[j]) bank[j] <= '0;
      else if (o_ld[j]) bank[j] <= o_wdata;

  // Reference model: round-robin by modular search, last grantee as an index.
  int           m_ptr  = 0;
  int           m_last = -1;
  logic [3:0]   m_gnt  = 4'b0000;
  logic [3:0]   m_ld   = 4'b0000;
  logic [3:0]   m_rclr = 4'b0000;
  logic [N-1:0] m_wdata = '0;
  logic [N-1:0] m_bank [4] = '{default: '0};

  always @(posedge clk) begin
    int win;
    for (int j = 0; j < 4; j++)
      if (!m_rclr[j]) m_bank[j] = '0;
      else if (m_ld[j]) m_bank[j] = m_wdata;
    if (clr) begin
      m_gnt = 0; m_ld = 0; m_wdata = 0; m_ptr = 0; m_rclr = 0; m_last = -1;
    end else if (clr_all) begin
      m_gnt = 0; m_ld = 0; m_rclr = 0; m_last = -1;
    end else begin
      m_rclr = 4'b1111;
      win = -1;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (win < 0 && req[i] && i != m_last) win = i;
      end
      if (win < 0) begin
        m_gnt = 0; m_ld = 0; m_last = -1;
      end else begin
        m_gnt   = 4'(1 << win);
        m_ld    = 4'(1 << int'(ra[win]));
        m_wdata = rd[win];
        m_ptr   = (win + 1) % 4;
        m_last  = win;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin ra[k] = 2'(k); rd[k] = 4'(k + 1); end
    clr = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc();
      n_checks++;
      if (o_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", o_gnt); end
      n_checks++;
      if (o_ld !== 4'b0000) begin n_fail++; $display("FAIL reset_ld: got %b want 0000", o_ld); end
      n_checks++;
      if (o_rclr_n !== 4'b0000) begin n_fail++; $display("FAIL reset_rclr_n: got %b want 0000", o_rclr_n); end
      n_checks++;
      if (o_wdata !== 4'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", o_wdata); end
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (bank[j] !== 4'h0) begin n_fail++; $display("FAIL reset_bank%0d: got %h want 0", j, bank[j]); end
    end
    clr = 1'b0;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 0001", o_gnt); end
    n_checks++;
    if (o_rclr_n !== 4'b1111) begin n_fail++; $display("FAIL reset_release_rclr_n: got %b want 1111", o_rclr_n); end
    req = 4'b0000;
    cyc();
    cyc();
  endtask

  task automatic test_single_write();
    req = 4'b0100; ra[2] = 2'd3; rd[2] = 4'hA;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", o_gnt); end
    n_checks++;
    if (o_ld !== 4'b1000) begin n_fail++; $display("FAIL single_ld: got %b want 1000", o_ld); end
    n_checks++;
    if (o_wdata !== 4'hA) begin n_fail++; $display("FAIL single_wdata: got %h want a", o_wdata); end
    req = 4'b0000;
    cyc();
    n_checks++;
    if (bank[3] !== 4'hA) begin n_fail++; $display("FAIL single_bank3: got %h want a", bank[3]); end
    n_checks++;
    if (o_gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt: got %b want 0000", o_gnt); end
  endtask

  task automatic test_contention();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin ra[k] = 2'(3 - k); rd[k] = 4'(k + 5); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++;
      if (o_gnt !== 4'(1 << k)) begin n_fail++; $display("FAIL contention_gnt%0d: got %b want %b", k, o_gnt, 4'(1 << k)); end
      n_checks++;
      if (o_ld !== 4'(1 << (3 - k))) begin n_fail++; $display("FAIL contention_ld%0d: got %b want %b", k, o_ld, 4'(1 << (3 - k))); end
      n_checks++;
      if (o_wdata !== 4'(k + 5)) begin n_fail++; $display("FAIL contention_wdata%0d: got %h want %h", k, o_wdata, 4'(k + 5)); end
      req[k] = 1'b0;
    end
    cyc();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bank[3 - k] !== 4'(k + 5)) begin n_fail++; $display("FAIL contention_bank%0d: got %h want %h", 3 - k, bank[3 - k], 4'(k + 5)); end
    end
  endtask

  task automatic test_wrap_around();
    int exp_seq [4] = '{1, 2, 1, 2};
    req = 4'b1001;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_first: got %b want 0001", o_gnt); end
    req[0] = 1'b0;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_second: got %b want 1000", o_gnt); end
    req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      cyc();
      n_checks++;
      if (o_gnt !== 4'(1 << exp_seq[c])) begin n_fail++; $display("FAIL wrap_alt%0d: got %b want %b", c, o_gnt, 4'(1 << exp_seq[c])); end
    end
    req = 4'b0000;
    cyc();
  endtask

  task automatic test_clr_all();
    req = 4'b0010; ra[1] = 2'd2; rd[1] = 4'h7;
    clr_all = 1'b1;
    cyc();
    n_checks++;
    if (o_rclr_n !== 4'b0000) begin n_fail++; $display("FAIL clr_all_rclr_n: got %b want 0000", o_rclr_n); end
    n_checks++;
    if (o_gnt !== 4'b0000) begin n_fail++; $display("FAIL clr_all_gnt: got %b want 0000", o_gnt); end
    n_checks++;
    if (o_ld !== 4'b0000) begin n_fail++; $display("FAIL clr_all_ld: got %b want 0000", o_ld); end
    clr_all = 1'b0;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b0010) begin n_fail++; $display("FAIL clr_all_resume_gnt: got %b want 0010", o_gnt); end
    n_checks++;
    if (o_rclr_n !== 4'b1111) begin n_fail++; $display("FAIL clr_all_resume_rclr_n: got %b want 1111", o_rclr_n); end
    req = 4'b0000;
    cyc();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (bank[j] !== ((j == 2) ? 4'h7 : 4'h0)) begin n_fail++; $display("FAIL clr_all_bank%0d: got %h want %h", j, bank[j], (j == 2) ? 4'h7 : 4'h0); end
    end
  endtask

  task automatic test_reset_mid_write();
    req = 4'b0001; ra[0] = 2'd1; rd[0] = 4'hF;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_gnt: got %b want 0001", o_gnt); end
    clr = 1'b1;
    req = 4'b0000;
    cyc();
    n_checks++;
    if (o_ld !== 4'b0000) begin n_fail++; $display("FAIL midrst_ld: got %b want 0000", o_ld); end
    n_checks++;
    if (o_rclr_n !== 4'b0000) begin n_fail++; $display("FAIL midrst_rclr_n: got %b want 0000", o_rclr_n); end
    cyc();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (bank[j] !== 4'h0) begin n_fail++; $display("FAIL midrst_bank%0d: got %h want 0", j, bank[j]); end
    end
    clr = 1'b0;
    req = 4'b1111;
    cyc();
    n_checks++;
    if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr: got %b want 0001", o_gnt); end
    req = 4'b0000;
    cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (o_gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          ra[i]  = 2'($urandom);
          rd[i]  = 4'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          ra[i]  = 2'($urandom);
          rd[i]  = 4'($urandom);
        end
      end
      clr_all = ($urandom_range(0, 19) == 0);
      clr     = ($urandom_range(0, 49) == 0);
      cyc();
      n_checks++;
      if (o_gnt !== m_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b want %b", c, o_gnt, m_gnt); end
      n_checks++;
      if (o_ld !== m_ld) begin n_fail++; $display("FAIL rand_ld c%0d: got %b want %b", c, o_ld, m_ld); end
      n_checks++;
      if (o_rclr_n !== m_rclr) begin n_fail++; $display("FAIL rand_rclr_n c%0d: got %b want %b", c, o_rclr_n, m_rclr); end
      n_checks++;
      if (o_wdata !== m_wdata) begin n_fail++; $display("FAIL rand_wdata c%0d: got %h want %h", c, o_wdata, m_wdata); end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (bank[j] !== m_bank[j]) begin n_fail++; $display("FAIL rand_bank%0d c%0d: got %h want %h", j, c, bank[j], m_bank[j]); end
      end
    end
    clr = 1'b0;
    clr_all = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin ra[k] = 2'd0; rd[k] = '0; end
    @(negedge clk);
    test_reset();
    test_single_write();
    test_contention();
    test_wrap_around();
    test_clr_all();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
